shift_reg_bank: RTL and testbench
=================================

SHIFT_REG_BANK -- requirements
Module: shift_reg_bank

Interface
REQ-001 SHALL have parameter BIT_SIZE, default 16, width of each word.
REQ-002 SHALL have parameter RAM_SIZE, default 8, number of words (>=2).
REQ-003 SHALL have derived parameter ADDR_W = clog2(RAM_SIZE), default 3; CNT_W = clog2(RAM_SIZE+1), default 4.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ld  input  1  parallel load of all words from par_in.
REQ-007 par_in  input  RAM_SIZE*BIT_SIZE  flattened load bus; word i at bits [i*BIT_SIZE +: BIT_SIZE].
REQ-008 shift_en  input  1  shift words up by one index, inserting shift_in at word 0.
REQ-009 shift_in  input  BIT_SIZE  word inserted on shift.
REQ-010 wr_en  input  1  single-word write.
REQ-011 wr_addr  input  ADDR_W  write index.
REQ-012 wr_data  input  BIT_SIZE  write data.
REQ-013 rd_en  input  1  single-word read request.
REQ-014 rd_addr  input  ADDR_W  read index.
REQ-015 par_out  output  RAM_SIZE*BIT_SIZE  registered flattened contents, same packing as par_in.
REQ-016 rd_data  output  BIT_SIZE  registered read data.
REQ-017 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-018 shift_out  output  BIT_SIZE  word evicted from index RAM_SIZE-1.
REQ-019 shift_out_valid  output  1  one-cycle pulse qualifying shift_out.
REQ-020 count  output  CNT_W  number of filled words.
REQ-021 full  output  1  count == RAM_SIZE; empty  output  1  count == 0.
REQ-022 addr_err  output  1  one-cycle pulse on out-of-range access.

Function
REQ-023 Update priority per cycle SHALL be rst > ld > shift_en > wr_en; lower-priority update requests in the same cycle are dropped without effect.
REQ-024 ld SHALL copy every word of par_in to par_out on the next edge and set count = RAM_SIZE.
REQ-025 shift_en (without ld) SHALL move word i to i+1 for i = 0..RAM_SIZE-2, load shift_in into word 0, and increment count saturating at RAM_SIZE.
REQ-026 shift_out_valid SHALL pulse high the cycle after a shift only if full was high when the shift was accepted; shift_out SHALL then hold the pre-shift word RAM_SIZE-1; otherwise shift_out_valid = 0 and shift_out holds its last value.
REQ-027 wr_en (without ld/shift_en) with wr_addr < RAM_SIZE SHALL write wr_data to that word; count unchanged.
REQ-028 rd_en SHALL return the word at rd_addr as it was before this cycle's update (read-before-write), with rd_valid high one cycle later; latency exactly 1.
REQ-029 rd_en is independent of priority and SHALL be serviced in every non-reset cycle, including cycles with ld, shift_en or wr_en.
REQ-030 rd_addr >= RAM_SIZE SHALL return rd_data = 0 with rd_valid = 1 and addr_err = 1 one cycle later.
REQ-031 Accepted wr_en with wr_addr >= RAM_SIZE SHALL be ignored and raise addr_err one cycle later; a dropped wr_en (REQ-023) SHALL not raise addr_err.
REQ-032 full and empty SHALL be combinational decodes of the count register.
REQ-033 rd_valid, shift_out_valid and addr_err SHALL be registered single-cycle pulses, low when no qualifying event occurred the previous cycle.

Reset
REQ-034 rst SHALL set every word of par_out, rd_data, shift_out and count to 0, and rd_valid, shift_out_valid, addr_err to 0; hence empty = 1, full = 0.
REQ-035 rst asserted mid-operation SHALL override any concurrent ld, shift_en, wr_en or rd_en; no pulse outputs SHALL be raised the following cycle.

Verification
REQ-036 Reset, then ld with word i = 0x1000+i -> next cycle par_out word i = 0x1000+i, count = 8, full = 1.
REQ-037 From empty, 8 shifts of 0xA0..0xA7 -> count 1..8, no shift_out_valid; 9th shift of 0xA8 -> shift_out = 0xA0, shift_out_valid = 1, word 0 = 0xA8, count = 8.
REQ-038 Same cycle: wr_en addr 2 data 0xBEEF and rd_en addr 2 after ld -> rd_data = 0x1002, rd_valid = 1; next read of addr 2 -> 0xBEEF.
REQ-039 Same cycle ld and shift_en and wr_en -> only ld takes effect, count = 8, shift_out_valid = 0.
REQ-040 RAM_SIZE = 6: rd_en addr 7 -> rd_data = 0, rd_valid = 1, addr_err = 1; wr_en addr 6 -> no word changes, addr_err = 1.
REQ-041 rst asserted together with shift_en while full -> next cycle all words 0, count = 0, shift_out_valid = 0.

Source files
------------

// File: rtl/shift_reg_bank.sv
// shift_reg_bank: bank of RAM_SIZE words of BIT_SIZE bits with parallel load,
// shift-in at word 0 / shift-out from the top word, and single-word write/read.
// Update priority is rst > ld > shift_en > wr_en. Reads are serviced every
// non-reset cycle and return pre-update contents one cycle later.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ld, par_in            parallel load of all words (word i at [i*BIT_SIZE +: BIT_SIZE])
//   shift_en, shift_in    shift words up one index, shift_in enters word 0
//   wr_en, wr_addr, wr_data   single-word write
//   rd_en, rd_addr        single-word read request
//   par_out               registered flattened contents
//   rd_data, rd_valid     registered read data and its one-cycle qualifier
//   shift_out, shift_out_valid  evicted top word and its one-cycle qualifier
//   count, full, empty    fill level and its combinational decodes
//   addr_err              one-cycle pulse on out-of-range read or accepted write
module shift_reg_bank #(
  parameter int unsigned BIT_SIZE = 16,
  parameter int unsigned RAM_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld,
  input  logic [RAM_SIZE*BIT_SIZE-1:0]   par_in,
  input  logic                           shift_en,
  input  logic [BIT_SIZE-1:0]            shift_in,
  input  logic                           wr_en,
  input  logic [$clog2(RAM_SIZE)-1:0]    wr_addr,
  input  logic [BIT_SIZE-1:0]            wr_data,
  input  logic                           rd_en,
  input  logic [$clog2(RAM_SIZE)-1:0]    rd_addr,
  output logic [RAM_SIZE*BIT_SIZE-1:0]   par_out,
  output logic [BIT_SIZE-1:0]            rd_data,
  output logic                           rd_valid,
  output logic [BIT_SIZE-1:0]            shift_out,
  output logic                           shift_out_valid,
  output logic [$clog2(RAM_SIZE+1)-1:0]  count,
  output logic                           full,
  output logic                           empty,
  output logic                           addr_err
);

  localparam int unsigned ADDR_W = $clog2(RAM_SIZE);
  localparam int unsigned CNT_W  = $clog2(RAM_SIZE + 1);

  logic [BIT_SIZE-1:0] mem_q [RAM_SIZE];
  logic [BIT_SIZE-1:0] mem_d [RAM_SIZE];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BIT_SIZE-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [BIT_SIZE-1:0] shift_out_q, shift_out_d;
  logic                shift_out_valid_q, shift_out_valid_d;
  logic                addr_err_q, addr_err_d;

  logic                rd_oor, wr_oor, full_now;

  // Out-of-range decode only matters when RAM_SIZE is not a power of two.
  assign rd_oor   = (32'(rd_addr) >= RAM_SIZE);
  assign wr_oor   = (32'(wr_addr) >= RAM_SIZE);
  assign full_now = (count_q == CNT_W'(RAM_SIZE));

  // Next-state logic: read path first, then the prioritised update.
  always_comb begin
    mem_d             = mem_q;
    count_d           = count_q;
    rd_data_d         = rd_data_q;
    rd_valid_d        = 1'b0;
    shift_out_d       = shift_out_q;
    shift_out_valid_d = 1'b0;
    addr_err_d        = 1'b0;

    // Read samples pre-update contents regardless of which update wins.
    if (rd_en) begin
      rd_valid_d = 1'b1;
      if (rd_oor) begin
        rd_data_d  = '0;
        addr_err_d = 1'b1;
      end else begin
        rd_data_d = mem_q[rd_addr];
      end
    end

    if (ld) begin
      for (int unsigned i = 0; i < RAM_SIZE; i++) begin
        mem_d[i] = par_in[i*BIT_SIZE +: BIT_SIZE];
      end
      count_d = CNT_W'(RAM_SIZE);
    end else if (shift_en) begin
      // Only a shift into a full bank evicts a meaningful word.
      if (full_now) begin
        shift_out_d       = mem_q[RAM_SIZE-1];
        shift_out_valid_d = 1'b1;
      end
      for (int unsigned i = 1; i < RAM_SIZE; i++) begin
        mem_d[i] = mem_q[i-1];
      end
      mem_d[0] = shift_in;
      if (!full_now) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (wr_en) begin
      if (wr_oor) begin
        addr_err_d = 1'b1;
      end else begin
        mem_d[wr_addr] = wr_data;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAM_SIZE; i++) begin
        mem_q[i] <= '0;
      end
      count_q           <= '0;
      rd_data_q         <= '0;
      rd_valid_q        <= 1'b0;
      shift_out_q       <= '0;
      shift_out_valid_q <= 1'b0;
      addr_err_q        <= 1'b0;
    end else begin
      mem_q             <= mem_d;
      count_q           <= count_d;
      rd_data_q         <= rd_data_d;
      rd_valid_q        <= rd_valid_d;
      shift_out_q       <= shift_out_d;
      shift_out_valid_q <= shift_out_valid_d;
      addr_err_q        <= addr_err_d;
    end
  end

  // Flatten word array onto the output bus.
  for (genvar g = 0; g < RAM_SIZE; g++) begin : g_par_out
    assign par_out[g*BIT_SIZE +: BIT_SIZE] = mem_q[g];
  end

  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign shift_out       = shift_out_q;
  assign shift_out_valid = shift_out_valid_q;
  assign count           = count_q;
  assign full            = full_now;
  assign empty           = (count_q == '0);
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench for shift_reg_bank: an 8x16 instance for load/shift/write/read
// behaviour and a 6x16 instance for out-of-range addressing.
module tb_shift_reg_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: RAM_SIZE = 8
  logic          a_ld, a_shift_en, a_wr_en, a_rd_en;
  logic [127:0]  a_par_in, a_par_out;
  logic [15:0]   a_shift_in, a_wr_data, a_rd_data, a_shift_out;
  logic [2:0]    a_wr_addr, a_rd_addr;
  logic [3:0]    a_count;
  logic          a_rd_valid, a_so_valid, a_full, a_empty, a_addr_err;

  shift_reg_bank #(.BIT_SIZE(16), .RAM_SIZE(8)) u_a (
    .clk(clk), .rst(rst), .ld(a_ld), .par_in(a_par_in),
    .shift_en(a_shift_en), .shift_in(a_shift_in),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .par_out(a_par_out), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .shift_out(a_shift_out), .shift_out_valid(a_so_valid),
    .count(a_count), .full(a_full), .empty(a_empty), .addr_err(a_addr_err)
  );

  // Instance B: RAM_SIZE = 6
  logic          b_ld, b_shift_en, b_wr_en, b_rd_en;
  logic [95:0]   b_par_in, b_par_out;
  logic [15:0]   b_shift_in, b_wr_data, b_rd_data, b_shift_out;
  logic [2:0]    b_wr_addr, b_rd_addr;
  logic [2:0]    b_count;
  logic          b_rd_valid, b_so_valid, b_full, b_empty, b_addr_err;

  shift_reg_bank #(.BIT_SIZE(16), .RAM_SIZE(6)) u_b (
    .clk(clk), .rst(rst), .ld(b_ld), .par_in(b_par_in),
    .shift_en(b_shift_en), .shift_in(b_shift_in),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .par_out(b_par_out), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .shift_out(b_shift_out), .shift_out_valid(b_so_valid),
    .count(b_count), .full(b_full), .empty(b_empty), .addr_err(b_addr_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs settle and inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_ld = 0; a_shift_en = 0; a_wr_en = 0; a_rd_en = 0;
    b_ld = 0; b_shift_en = 0; b_wr_en = 0; b_rd_en = 0;
  endtask

  logic [127:0] exp_a;
  logic [95:0]  exp_b;

  initial begin
    rst = 1'b1;
    idle_inputs();
    a_par_in = '0; a_shift_in = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
    b_par_in = '0; b_shift_in = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_par_out", a_par_out, '0);
    chk("rst_count", 128'(a_count), 128'd0);
    chk("rst_empty", 128'(a_empty), 128'd1);
    chk("rst_full", 128'(a_full), 128'd0);
    chk("rst_pulses", 128'({a_rd_valid, a_so_valid, a_addr_err}), 128'd0);
    chk("rst_rd_data", 128'(a_rd_data), 128'd0);

    // Parallel load word i = 0x1000+i
    for (int i = 0; i < 8; i++) a_par_in[i*16 +: 16] = 16'(16'h1000 + i);
    a_ld = 1;
    tick();
    a_ld = 0;
    chk("ld_par_out", a_par_out, a_par_in);
    chk("ld_count", 128'(a_count), 128'd8);
    chk("ld_full", 128'({a_full, a_empty}), 128'b10);

    // Same-cycle write and read of addr 2: read sees old value
    a_wr_en = 1; a_wr_addr = 3'd2; a_wr_data = 16'hBEEF;
    a_rd_en = 1; a_rd_addr = 3'd2;
    tick();
    a_wr_en = 0;
    chk("rbw_rd_data", 128'(a_rd_data), 128'h1002);
    chk("rbw_rd_valid", 128'(a_rd_valid), 128'd1);
    chk("rbw_addr_err", 128'(a_addr_err), 128'd0);
    tick();
    a_rd_en = 0;
    chk("rd_after_wr", 128'(a_rd_data), 128'hBEEF);
    chk("wr_count", 128'(a_count), 128'd8);
    tick();
    chk("rd_valid_pulse", 128'(a_rd_valid), 128'd0);

    // ld + shift_en + wr_en together: only ld applies
    for (int i = 0; i < 8; i++) a_par_in[i*16 +: 16] = 16'(16'h2000 + i);
    a_ld = 1; a_shift_en = 1; a_shift_in = 16'h5555;
    a_wr_en = 1; a_wr_addr = 3'd0; a_wr_data = 16'h7777;
    tick();
    idle_inputs();
    chk("prio_par_out", a_par_out, a_par_in);
    chk("prio_count", 128'(a_count), 128'd8);
    chk("prio_so_valid", 128'(a_so_valid), 128'd0);

    // Shift + write: shift wins, write dropped
    a_shift_en = 1; a_shift_in = 16'h0101;
    a_wr_en = 1; a_wr_addr = 3'd7; a_wr_data = 16'hDEAD;
    tick();
    idle_inputs();
    chk("shwr_so", 128'(a_shift_out), 128'h2007);
    chk("shwr_so_valid", 128'(a_so_valid), 128'd1);
    chk("shwr_w7", 128'(a_par_out[7*16 +: 16]), 128'h2006);
    chk("shwr_w0", 128'(a_par_out[15:0]), 128'h0101);

    // Reset during shift while full
    rst = 1; a_shift_en = 1; a_shift_in = 16'hFFFF; a_rd_en = 1; a_rd_addr = 3'd1;
    tick();
    rst = 0; idle_inputs();
    chk("rstmid_par_out", a_par_out, '0);
    chk("rstmid_count", 128'(a_count), 128'd0);
    chk("rstmid_pulses", 128'({a_rd_valid, a_so_valid, a_addr_err}), 128'd0);
    chk("rstmid_empty", 128'(a_empty), 128'd1);

    // Fill from empty with 0xA0..0xA7
    for (int k = 0; k < 8; k++) begin
      a_shift_en = 1; a_shift_in = 16'(16'hA0 + k);
      tick();
      a_shift_en = 0;
      chk("fill_count", 128'(a_count), 128'(k + 1));
      chk("fill_so_valid", 128'(a_so_valid), 128'd0);
    end
    for (int i = 0; i < 8; i++) exp_a[i*16 +: 16] = 16'(16'hA7 - i);
    chk("fill_par_out", a_par_out, exp_a);
    a_shift_en = 1; a_shift_in = 16'hA8;
    tick();
    a_shift_en = 0;
    chk("evict_so", 128'(a_shift_out), 128'hA0);
    chk("evict_so_valid", 128'(a_so_valid), 128'd1);
    chk("evict_w0", 128'(a_par_out[15:0]), 128'hA8);
    chk("evict_w7", 128'(a_par_out[7*16 +: 16]), 128'hA1);
    chk("evict_count", 128'(a_count), 128'd8);
    tick();
    chk("so_pulse_low", 128'(a_so_valid), 128'd0);
    chk("so_hold", 128'(a_shift_out), 128'hA0);

    // Instance B (6 words): out-of-range accesses
    for (int i = 0; i < 6; i++) b_par_in[i*16 +: 16] = 16'(16'h0300 + i);
    b_ld = 1;
    tick();
    b_ld = 0;
    chk("b_ld_par_out", 128'(b_par_out), 128'(b_par_in));
    chk("b_ld_full", 128'({b_full, b_count}), 128'({1'b1, 3'd6}));
    b_rd_en = 1; b_rd_addr = 3'd7;
    tick();
    b_rd_en = 0;
    chk("b_rd_oor_data", 128'(b_rd_data), 128'd0);
    chk("b_rd_oor_flags", 128'({b_rd_valid, b_addr_err}), 128'b11);
    b_wr_en = 1; b_wr_addr = 3'd6; b_wr_data = 16'hFFFF;
    tick();
    b_wr_en = 0;
    chk("b_wr_oor_err", 128'(b_addr_err), 128'd1);
    chk("b_wr_oor_par", 128'(b_par_out), 128'(b_par_in));
    chk("b_wr_oor_rdv", 128'(b_rd_valid), 128'd0);
    tick();
    chk("b_err_pulse_low", 128'(b_addr_err), 128'd0);
    // Dropped out-of-range write raises no error
    b_shift_en = 1; b_shift_in = 16'h0042;
    b_wr_en = 1; b_wr_addr = 3'd7;
    tick();
    idle_inputs();
    chk("b_drop_err", 128'(b_addr_err), 128'd0);
    chk("b_drop_so", 128'({b_so_valid, b_shift_out}), 128'({1'b1, 16'h0305}));
    exp_b = {b_par_in[79:0], 16'h0042};
    chk("b_drop_par", 128'(b_par_out), 128'(exp_b));
    // In-range read on B
    b_rd_en = 1; b_rd_addr = 3'd5;
    tick();
    b_rd_en = 0;
    chk("b_rd_w5", 128'({b_rd_valid, b_addr_err, b_rd_data}), 128'({2'b10, 16'h0304}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
